// File: rtl/divu_if.sv
// Handshake and data bundle between the execute stage and the unsigned divider.
interface divu_if #(
   parameter int WIDTH = 32
);
   logic               start;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic               busy;
   logic               done;
   logic               dz;
   logic [2*WIDTH-1:0] z;

   // Execute stage side: issues operands, watches the handshake and result.
   modport master (
      output start, a, b,
      input  busy, done, dz, z
   );

   // Divider side.
   modport slave (
      input  start, a, b,
      output busy, done, dz, z
   );
endinterface

// File: rtl/divu_seq.sv
// Iterative restoring unsigned divider for DIVU: one quotient bit per clock,
// result packed as {remainder, quotient} to match the HI:LO layout of the multiplier.
module divu_seq #(
   parameter int WIDTH = 32
) (
   input  logic   clk,
   input  logic   rst,
   divu_if.slave  bus
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t               state;
   logic [WIDTH-1:0]     b_reg;
   logic [WIDTH-1:0]     rem;
   logic [WIDTH-1:0]     quo;
   logic [CNT_W-1:0]     cnt;
   logic                 busy_r;
   logic                 done_r;
   logic                 dz_r;
   logic [2*WIDTH-1:0]   z_r;
   logic [2*WIDTH-1:0]   step;

   // One restoring step. The trial value is WIDTH+1 bits so a divisor with its
   // top bit set still compares correctly against a shifted-in carry.
   function automatic logic [2*WIDTH-1:0] div_step(
      input logic [WIDTH-1:0] r,
      input logic [WIDTH-1:0] q,
      input logic [WIDTH-1:0] d
   );
      logic [WIDTH:0] t;
      logic [WIDTH:0] diff;
      t    = {r, q[WIDTH-1]};
      diff = t - {1'b0, d};
      if (t >= {1'b0, d})
         return {diff[WIDTH-1:0], q[WIDTH-2:0], 1'b1};
      else
         return {t[WIDTH-1:0], q[WIDTH-2:0], 1'b0};
   endfunction

   assign step = div_step(rem, quo, b_reg);

   // Control FSM and datapath: accept in IDLE/DONE, iterate WIDTH times in RUN,
   // register the packed result and divide-by-zero flag on the final step.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         b_reg  <= '0;
         rem    <= '0;
         quo    <= '0;
         cnt    <= '0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         dz_r   <= 1'b0;
         z_r    <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done_r <= 1'b0;
               if (bus.start) begin
                  b_reg  <= bus.b;
                  rem    <= '0;
                  quo    <= bus.a;
                  cnt    <= '0;
                  busy_r <= 1'b1;
                  state  <= RUN;
               end else begin
                  state  <= IDLE;
               end
            end
            RUN: begin
               // start is deliberately ignored here; requests are not queued.
               rem <= step[2*WIDTH-1:WIDTH];
               quo <= step[WIDTH-1:0];
               cnt <= cnt + 1'b1;
               if (cnt == LAST_ITER) begin
                  z_r    <= step;
                  dz_r   <= (b_reg == '0);
                  busy_r <= 1'b0;
                  done_r <= 1'b1;
                  state  <= DONE;
               end
            end
            default: begin
               busy_r <= 1'b0;
               done_r <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.dz   = dz_r;
   assign bus.z    = z_r;

endmodule

// File: tb/tb_divu_seq.sv
// Directed bench for divu_seq with a result scoreboard fed from a reference model.
module tb_divu_seq;

   localparam int W = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;
   logic [2*W:0] sb_q[$];   // {dz, remainder, quotient}

   divu_if #(.WIDTH(W)) bus ();

   divu_seq #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference: plain integer divide; divide by zero yields all-ones quotient and remainder = a.
   function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
      if (b == '0)
         return {1'b1, a, {W{1'b1}}};
      else
         return {1'b0, a % b, a / b};
   endfunction

   task automatic check(input string tag, input logic [2*W:0] got, input logic [2*W:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called at a negedge; drives a request there and returns at the negedge after acceptance.
   task automatic start_div(input logic [W-1:0] a, input logic [W-1:0] b);
      bus.a     = a;
      bus.b     = b;
      bus.start = 1'b1;
      sb_q.push_back(model(a, b));
      @(negedge clk);
      bus.start = 1'b0;
      bus.a     = $urandom;
      bus.b     = $urandom;
   endtask

   // n0 = edges elapsed since acceptance at the current negedge.
   task automatic wait_result(input string tag, input int n0);
      int           n;
      int           busy_cnt;
      bit           z_moved;
      logic [2*W-1:0] z_prev;
      logic [2*W:0]   exp;
      n        = n0;
      busy_cnt = 0;
      z_moved  = 1'b0;
      z_prev   = bus.z;
      while (!bus.done && n < 100) begin
         if (bus.busy) busy_cnt++;
         if (bus.z !== z_prev) z_moved = 1'b1;
         @(negedge clk);
         n++;
      end
      check({tag, " latency"}, n, W + 1);
      check({tag, " busy_cycles"}, busy_cnt, W + 1 - n0);
      check({tag, " z_stable_while_busy"}, z_moved, 1'b0);
      check({tag, " busy_at_done"}, bus.busy, 1'b0);
      if (sb_q.size() == 0) begin
         check({tag, " scoreboard_empty"}, 1'b1, 1'b0);
      end else begin
         exp = sb_q.pop_front();
         check({tag, " z"}, bus.z, exp[2*W-1:0]);
         check({tag, " dz"}, bus.dz, exp[2*W]);
      end
   endtask

   initial begin
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      repeat (3) @(negedge clk);

      check("reset busy", bus.busy, 1'b0);
      check("reset done", bus.done, 1'b0);
      check("reset dz", bus.dz, 1'b0);
      check("reset z", bus.z, '0);
      rst = 1'b0;
      @(negedge clk);

      // Basic divide, also cross-checked against the literal expected packing.
      start_div(32'd100, 32'd7);
      wait_result("100/7", 1);
      check("100/7 literal", bus.z, 64'h0000_0002_0000_000E);
      @(negedge clk);
      check("done one cycle", bus.done, 1'b0);

      // Divisor with top bit set exercises the wide compare.
      start_div(32'hFFFF_FFFF, 32'h8000_0001);
      wait_result("wide_cmp", 1);
      check("wide_cmp literal", bus.z, {32'h7FFF_FFFE, 32'h1});
      @(negedge clk);
      start_div(32'hFFFF_FFFF, 32'd1);
      wait_result("max/1", 1);
      @(negedge clk);
      start_div(32'd5, 32'd9);
      wait_result("5/9", 1);
      @(negedge clk);
      start_div(32'd0, 32'd3);
      wait_result("0/3", 1);

      // Divide by zero, then a normal divide clears dz.
      @(negedge clk);
      start_div(32'd1234, 32'd0);
      wait_result("1234/0", 1);
      check("1234/0 literal", bus.z, {32'd1234, 32'hFFFF_FFFF});
      @(negedge clk);
      start_div(32'd10, 32'd3);
      wait_result("10/3", 1);

      // start while busy is ignored; start during done is accepted back-to-back.
      @(negedge clk);
      start_div(32'd100, 32'd7);
      repeat (9) @(negedge clk);
      bus.a     = 32'd1;
      bus.b     = 32'd1;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_result("ignored_start", 11);
      start_div(32'd9, 32'd2);
      wait_result("b2b 9/2", 1);

      // Abort mid-divide with reset: everything clears and no done follows.
      @(negedge clk);
      start_div(32'd100, 32'd7);
      repeat (19) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      sb_q.delete();
      check("abort busy", bus.busy, 1'b0);
      check("abort done", bus.done, 1'b0);
      check("abort z", bus.z, '0);
      check("abort dz", bus.dz, 1'b0);
      begin
         bit saw_done;
         saw_done = 1'b0;
         repeat (40) begin
            if (bus.done || bus.busy) saw_done = 1'b1;
            @(negedge clk);
         end
         check("abort no_done", saw_done, 1'b0);
      end
      start_div(32'd50, 32'd5);
      wait_result("50/5", 1);

      // A few random operands, including the occasional zero divisor.
      for (int i = 0; i < 6; i++) begin
         logic [W-1:0] ra;
         logic [W-1:0] rb;
         ra = $urandom;
         rb = (i == 3) ? '0 : ($urandom >> $urandom_range(0, 31));
         @(negedge clk);
         start_div(ra, rb);
         wait_result("random", 1);
      end

      check("scoreboard drained", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
